// File: rtl/ysyx_23060240_idu.sv
// ysyx_23060240_idu: RV32 decode stage with registered output slot and one-entry skid buffer
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_pc/in_inst from fetch;
//   flush from execute; out_valid/out_ready plus decoded out_* fields to execute.
// Build option: define IDU_RV32E_EN to flag register indices >= 16 as illegal (RV32E).
module ysyx_23060240_idu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_opclass,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [31:0] out_imm,
  output logic        out_rf_wen,
  output logic        out_ebreak,
  output logic        out_illegal
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        rf_wen;
    logic        ebreak;
    logic        illegal;
  } entry_t;
  state_t state, state_n;
  entry_t main_q, skid_q, dec;
  logic [6:0] op;
  logic [3:0] cls;
  logic [31:0] imm;
  logic reg_bad, bad, acc, fire;
  assign op = in_inst[6:0];
  always_comb begin
    cls = op == 7'h37 ? 4'd0 : op == 7'h17 ? 4'd1 : op == 7'h6f ? 4'd2 : op == 7'h67 ? 4'd3 :
          op == 7'h63 ? 4'd4 : op == 7'h03 ? 4'd5 : op == 7'h23 ? 4'd6 : op == 7'h13 ? 4'd7 :
          op == 7'h33 ? 4'd8 : op == 7'h73 ? 4'd9 : 4'd15;
    imm = (cls == 4'd3 || cls == 4'd5 || cls == 4'd7 || cls == 4'd9) ? {{20{in_inst[31]}}, in_inst[31:20]} :
          cls == 4'd6 ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
          cls == 4'd4 ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
          (cls == 4'd0 || cls == 4'd1) ? {in_inst[31:12], 12'b0} :
          cls == 4'd2 ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} : 32'b0;
`ifdef IDU_RV32E_EN
    reg_bad = cls == 4'd8 ? (in_inst[11] | in_inst[19] | in_inst[24]) :
              (cls == 4'd3 || cls == 4'd5 || cls == 4'd7) ? (in_inst[11] | in_inst[19]) :
              (cls == 4'd4 || cls == 4'd6) ? (in_inst[19] | in_inst[24]) :
              cls <= 4'd2 ? in_inst[11] : 1'b0;
`else
    reg_bad = 1'b0;
`endif
    bad = cls == 4'd15 || reg_bad;
    dec.pc       = in_pc;
    dec.opclass  = bad ? 4'd15 : cls;
    dec.rd       = in_inst[11:7];
    dec.rs1      = in_inst[19:15];
    dec.rs2      = in_inst[24:20];
    dec.funct3   = in_inst[14:12];
    dec.funct7b5 = in_inst[30];
    dec.imm      = bad ? 32'b0 : imm;
    dec.rf_wen   = !bad && in_inst[11:7] != 5'd0 && (cls <= 4'd3 || cls == 4'd5 || cls == 4'd7 || cls == 4'd8);
    dec.ebreak   = !bad && in_inst == 32'h00100073;
    dec.illegal  = bad;
  end
  assign in_ready  = state != SKID;
  assign out_valid = state != EMPTY;
  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;
  always_comb begin
    state_n = flush ? EMPTY :
              state == EMPTY ? (acc ? FULL : EMPTY) :
              state == FULL ? (acc && !fire ? SKID : !acc && fire ? EMPTY : FULL) :
              (fire ? FULL : SKID);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (!flush) begin
        if (state == SKID && fire) main_q <= skid_q;
        else if (acc && (state == EMPTY || fire)) main_q <= dec;
        if (acc && state == FULL && !fire) skid_q <= dec;
      end
    end
  end
  assign out_pc       = main_q.pc;
  assign out_opclass  = main_q.opclass;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_funct3   = main_q.funct3;
  assign out_funct7b5 = main_q.funct7b5;
  assign out_imm      = main_q.imm;
  assign out_rf_wen   = main_q.rf_wen;
  assign out_ebreak   = main_q.ebreak;
  assign out_illegal  = main_q.illegal;
endmodule

// File: tb/tb_ysyx_23060240_idu.sv
// tb_ysyx_23060240_idu: randomized and directed checks of the decode stage against a queue-based model
module tb_ysyx_23060240_idu;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid, out_funct7b5, out_rf_wen, out_ebreak, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [3:0] out_opclass;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3;
  int n_cmp = 0, n_fail = 0;
  logic [89:0] q[$];
  localparam logic [6:0] OPS [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
  localparam logic [31:0] T_INST [6] = '{32'h00500093, 32'h12345137, 32'hFE000EE3, 32'h00100073, 32'h00000000, 32'h00208833};
`ifdef IDU_RV32E_EN
  localparam logic [3:0]  T_CLS [6] = '{4'd7, 4'd0, 4'd4, 4'd9, 4'd15, 4'd15};
  localparam logic        T_WEN [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic        T_ILL [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
  localparam logic [3:0]  T_CLS [6] = '{4'd7, 4'd0, 4'd4, 4'd9, 4'd15, 4'd8};
  localparam logic        T_WEN [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic        T_ILL [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
  localparam logic [4:0]  T_RD  [6] = '{5'd1, 5'd2, 5'd29, 5'd0, 5'd0, 5'd16};
  localparam logic [31:0] T_IMM [6] = '{32'd5, 32'h12345000, 32'hFFFFFFFC, 32'd1, 32'd0, 32'd0};
  localparam logic        T_EB  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  always #5 clk = ~clk;
  ysyx_23060240_idu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opclass(out_opclass),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_imm(out_imm), .out_rf_wen(out_rf_wen), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );
  function automatic logic [89:0] ref_decode(logic [31:0] pc, logic [31:0] i);
    int cls;
    logic [31:0] imm;
    bit wb, bad;
    bit use_rd, use_rs1, use_rs2;
    imm = 0; wb = 0; use_rd = 0; use_rs1 = 0; use_rs2 = 0;
    case (i[6:0])
      7'h37: begin cls = 0; imm = {i[31:12], 12'b0}; wb = 1; use_rd = 1; end
      7'h17: begin cls = 1; imm = {i[31:12], 12'b0}; wb = 1; use_rd = 1; end
      7'h6f: begin cls = 2; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); wb = 1; use_rd = 1; end
      7'h67: begin cls = 3; imm = 32'($signed(i[31:20])); wb = 1; use_rd = 1; use_rs1 = 1; end
      7'h63: begin cls = 4; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); use_rs1 = 1; use_rs2 = 1; end
      7'h03: begin cls = 5; imm = 32'($signed(i[31:20])); wb = 1; use_rd = 1; use_rs1 = 1; end
      7'h23: begin cls = 6; imm = 32'($signed({i[31:25], i[11:7]})); use_rs1 = 1; use_rs2 = 1; end
      7'h13: begin cls = 7; imm = 32'($signed(i[31:20])); wb = 1; use_rd = 1; use_rs1 = 1; end
      7'h33: begin cls = 8; wb = 1; use_rd = 1; use_rs1 = 1; use_rs2 = 1; end
      7'h73: begin cls = 9; imm = 32'($signed(i[31:20])); end
      default: cls = 15;
    endcase
    bad = cls == 15;
`ifdef IDU_RV32E_EN
    if ((use_rd && i[11:7] >= 16) || (use_rs1 && i[19:15] >= 16) || (use_rs2 && i[24:20] >= 16)) bad = 1;
`endif
    if (bad) begin cls = 15; imm = 0; wb = 0; end
    return {pc, 4'(cls), i[11:7], i[19:15], i[24:20], i[14:12], i[30], imm,
            wb && i[11:7] != 0, !bad && i == 32'h00100073, bad};
  endfunction
  function automatic logic [89:0] fields();
    return {out_pc, out_opclass, out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5, out_imm, out_rf_wen, out_ebreak, out_illegal};
  endfunction
  function automatic logic [91:0] dut_vec();
    return {out_valid, in_ready, out_valid ? fields() : 90'b0};
  endfunction
  function automatic logic [91:0] exp_vec();
    return {q.size() > 0, q.size() < 2, q.size() > 0 ? q[0] : 90'b0};
  endfunction
  task automatic tick();
    bit acc, fire;
    acc = in_valid && q.size() < 2;
    fire = q.size() > 0 && out_ready;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(ref_decode(in_pc, in_inst));
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    tick(); tick();
    n_cmp++;
    if ({out_valid, in_ready, fields()} !== {1'b0, 1'b1, 90'b0}) begin
      n_fail++; $display("FAIL reset: got %h want %h", {out_valid, in_ready, fields()}, {1'b0, 1'b1, 90'b0});
    end
    rst = 0;
  endtask
  task automatic test_decode();
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_pc = 32'h80000000 + 32'(4 * k); in_inst = T_INST[k];
      tick();
      in_valid = 0;
      n_cmp++;
      if ({out_valid, out_pc, out_opclass, out_rd, out_imm, out_rf_wen, out_ebreak, out_illegal} !==
          {1'b1, 32'h80000000 + 32'(4 * k), T_CLS[k], T_RD[k], T_IMM[k], T_WEN[k], T_EB[k], T_ILL[k]}) begin
        n_fail++;
        $display("FAIL decode %h: got v%0d pc %h cls %0d rd %0d imm %h wen %0d eb %0d ill %0d want cls %0d rd %0d imm %h wen %0d eb %0d ill %0d",
                 T_INST[k], out_valid, out_pc, out_opclass, out_rd, out_imm, out_rf_wen, out_ebreak, out_illegal,
                 T_CLS[k], T_RD[k], T_IMM[k], T_WEN[k], T_EB[k], T_ILL[k]);
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL decode_model %h: got %h want %h", T_INST[k], dut_vec(), exp_vec());
      end
    end
    tick(); tick();
  endtask
  task automatic test_back_to_back();
    logic exp_r [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_pc [6] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h108, 32'h0};
    out_ready = 0; in_valid = 1;
    for (int s = 0; s < 6; s++) begin
      if (s < 3) begin in_pc = 32'h100 + 32'(4 * s); in_inst = 32'h00000013 | 32'((s + 1) << 7); end
      if (s == 3) out_ready = 1;
      tick();
      if (s == 4) in_valid = 0;
      n_cmp++;
      if (in_ready !== exp_r[s] || out_valid !== exp_v[s] || (exp_v[s] && out_pc !== exp_pc[s])) begin
        n_fail++; $display("FAIL back_to_back step %0d: got rdy %0d v %0d pc %h want rdy %0d v %0d pc %h",
                           s, in_ready, out_valid, out_pc, exp_r[s], exp_v[s], exp_pc[s]);
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL back_to_back_model step %0d: got %h want %h", s, dut_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    for (int s = 0; s < 2; s++) begin
      in_pc = 32'h200 + 32'(4 * s); in_inst = 32'h00a00113;
      tick();
    end
    in_pc = 32'h300; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL flush step %0d: got v %0d rdy %0d want v 0 rdy 1", s, out_valid, in_ready);
      end
      out_ready = 1;
      tick();
    end
  endtask
  task automatic test_random();
    int k;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      flush = $urandom_range(0, 15) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_pc = $urandom();
      in_inst = $urandom();
      k = $urandom_range(0, 12);
      if (k < 10) in_inst[6:0] = OPS[k];
      else if (k == 10) in_inst = 32'h00100073;
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    rst = 0; flush = 0; in_valid = 0;
  endtask
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
